// File: rtl/core_run_pkg.sv
// core_run_pkg
//   Shared types and constants for the core run sequencer.
//   run_state_t : sequencer state encoding
//   RST_HOLD    : number of cycles the core is held in reset after the load
package core_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RST  = 3'd2,
    S_RUN  = 3'd3,
    S_RD   = 3'd4,
    S_OUT  = 3'd5
  } run_state_t;

  localparam int RST_HOLD = 2;

endpackage

// File: rtl/tmo_counter.sv
// tmo_counter
//   Loadable up-counter with synchronous clear and a terminal-count flag.
//   Priority: clear > load > increment.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   i_clr          synchronous clear to zero
//   i_ld/i_ld_val  synchronous load
//   i_inc          increment by one
//   i_tc_val       terminal-count compare value
//   o_cnt          current count
//   o_tc           1 when o_cnt == i_tc_val
module tmo_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_tc_val);

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl
//   Host-side run sequencer for the CPU core: loads operand bytes into data
//   memory with the core held in reset, releases the core, waits for done
//   under a cycle timeout, then streams a result window back to the host.
//
//   state | meaning
//   IDLE  | core in reset, waiting for go
//   LOAD  | accepting host bytes, writing data memory
//   RST   | core held in reset for RST_HOLD cycles after the load
//   RUN   | core released, owns data memory, timeout running
//   RD    | read address for the next result byte presented
//   OUT   | result byte offered to host until out_ready
//
// Ports:
//   clk, reset                         clock, async active-low reset
//   go                                 start pulse (IDLE only)
//   in_valid/in_data/in_ready          host load stream
//   out_valid/out_data/out_last/out_ready  host result stream
//   core_reset/core_req/core_done      core control
//   mem_own/mem_wr_en/mem_addr/mem_wdat/mem_rdat  data-memory port
//   busy, err                          status (err sticky until next go)
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int AW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_LEN   = 16,
  parameter int TMO       = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdat,
  input  logic [7:0]    mem_rdat,
  output logic          busy,
  output logic          err
);

  // Beat counter must reach 2^AW - 1; timeout counter must hold TMO.
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO + 1);

  run_state_t r_state, w_next;
  logic       r_done_q;
  logic       r_err;
  logic       r_fresh;
  logic [7:0] r_out_data;

  logic          w_beat_clr, w_beat_inc, w_beat_tc;
  logic [CW-1:0] w_beat_cnt, w_beat_tc_val;
  logic          w_tmo_clr, w_tmo_inc, w_tmo_tc;
  logic [TW-1:0] w_tmo_cnt;
  logic          w_set_err, w_clr_err;
  logic          w_beat_acc;
  logic          w_rst_done;
  logic [AW-1:0] w_addr_load, w_addr_res;

  assign w_beat_tc_val = (r_state == S_LOAD) ? CW'(LOAD_LEN - 1) : CW'(RES_LEN - 1);

  tmo_counter #(.W(CW)) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_beat_clr),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .i_inc    (w_beat_inc),
    .i_tc_val (w_beat_tc_val),
    .o_cnt    (w_beat_cnt),
    .o_tc     (w_beat_tc)
  );

  // Also times the RST hold, so RUN always starts from a cleared count.
  tmo_counter #(.W(TW)) u_tmo_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_tmo_clr),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .i_inc    (w_tmo_inc),
    .i_tc_val (TW'(TMO - 1)),
    .o_cnt    (w_tmo_cnt),
    .o_tc     (w_tmo_tc)
  );

  assign w_rst_done  = (w_tmo_cnt == TW'(RST_HOLD - 1));
  assign w_beat_acc  = (r_state == S_LOAD) && in_valid;
  // Address arithmetic wraps modulo 2^AW via the final cast.
  assign w_addr_load = AW'(CW'(LOAD_BASE) + w_beat_cnt);
  assign w_addr_res  = AW'(CW'(RES_BASE) + w_beat_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_done_q   <= 1'b0;
      r_err      <= 1'b0;
      r_fresh    <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_state  <= w_next;
      r_done_q <= (r_state == S_RUN) && core_done;
      r_fresh  <= (r_state == S_RD);
      if (w_clr_err) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
      if ((r_state == S_OUT) && r_fresh) begin
        r_out_data <= mem_rdat;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_beat_clr = 1'b0;
    w_beat_inc = 1'b0;
    w_tmo_clr  = 1'b0;
    w_tmo_inc  = 1'b0;
    w_set_err  = 1'b0;
    w_clr_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (go) begin
          w_beat_clr = 1'b1;
          w_tmo_clr  = 1'b1;
          w_clr_err  = 1'b1;
          w_next     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_beat_acc) begin
          w_beat_inc = 1'b1;
          if (w_beat_tc) begin
            w_beat_clr = 1'b1;
            w_next     = S_RST;
          end
        end
      end
      S_RST: begin
        w_tmo_inc = 1'b1;
        if (w_rst_done) begin
          w_tmo_clr = 1'b1;
          w_next    = S_RUN;
        end
      end
      S_RUN: begin
        w_tmo_inc = 1'b1;
        // done_q has priority over a timeout in the same cycle.
        if (r_done_q) begin
          w_tmo_clr = 1'b1;
          w_next    = S_RD;
        end else if (w_tmo_tc) begin
          w_set_err = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_RD: begin
        w_next = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (w_beat_tc) begin
            w_next = S_IDLE;
          end else begin
            w_beat_inc = 1'b1;
            w_next     = S_RD;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    case (r_state)
      S_LOAD:      mem_addr = w_addr_load;
      S_RD, S_OUT: mem_addr = w_addr_res;
      default:     mem_addr = '0;
    endcase
  end

  assign in_ready   = (r_state == S_LOAD);
  assign mem_wr_en  = w_beat_acc;
  assign mem_wdat   = (r_state == S_LOAD) ? in_data : 8'h00;
  assign core_reset = (r_state != S_RUN);
  assign core_req   = (r_state == S_RUN);
  assign mem_own    = (r_state != S_RUN);
  assign out_valid  = (r_state == S_OUT);
  assign out_last   = (r_state == S_OUT) && w_beat_tc;
  // Read data arrives during the first OUT cycle; pass it through then and
  // hold the captured copy for as long as the host stalls.
  assign out_data   = ((r_state == S_OUT) && r_fresh) ? mem_rdat : r_out_data;
  assign busy       = (r_state != S_IDLE);
  assign err        = r_err;

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

  localparam int AW        = 8;
  localparam int LOAD_BASE = 0;
  localparam int LOAD_LEN  = 4;
  localparam int RES_BASE  = 64;
  localparam int RES_LEN   = 16;
  localparam int TMO       = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_ready;
  logic          core_reset;
  logic          core_req;
  logic          core_done;
  logic          mem_own;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdat;
  logic [7:0]    mem_rdat;
  logic          busy;
  logic          err;

  core_run_ctrl #(
    .AW(AW), .LOAD_BASE(LOAD_BASE), .LOAD_LEN(LOAD_LEN),
    .RES_BASE(RES_BASE), .RES_LEN(RES_LEN), .TMO(TMO)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
    .mem_own(mem_own), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous read, data valid one cycle after the address.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_own && mem_wr_en) mem[mem_addr] <= mem_wdat;
    mem_rdat <= mem[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  logic [15:0] wq[$];   // expected {addr, data} writes
  logic [8:0]  oq[$];   // expected {last, data} result beats
  logic [15:0] w_exp;
  logic [8:0]  o_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none expected", mem_addr, mem_wdat);
      end else begin
        w_exp = wq.pop_front();
        chk("mem_write", 32'({mem_addr, mem_wdat}), 32'(w_exp));
      end
    end
  end

  // Result-stream monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (oq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: data 0x%0h with none expected", out_data);
      end else begin
        o_exp = oq.pop_front();
        chk("out_beat", 32'({out_last, out_data}), 32'(o_exp));
      end
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk(nm, 32'({core_reset, core_req, mem_own, mem_wr_en, in_ready, out_valid,
                 out_last, busy, err, out_data}),
        32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
  endtask

  task automatic push_outs();
    for (int i = 0; i < RES_LEN; i++)
      oq.push_back({(i == RES_LEN - 1), 8'hA0 + 8'(i)});
  endtask

  task automatic load4(input logic [31:0] b);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < LOAD_LEN; i++) begin
      in_valid = 1'b1;
      in_data  = b[31-8*i -: 8];
      wq.push_back({8'(LOAD_BASE + i), b[31-8*i -: 8]});
      @(negedge clk);
      chk("load_wr_en", 32'(mem_wr_en), 32'd1);
      if (i == 0) begin
        chk("in_ready_after_go", 32'(in_ready), 32'd1);
        chk("err_cleared_by_go", 32'(err), 32'd0);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 1;
    while (!core_req && n < 50) begin
      tick();
      n++;
    end
    chk("last_beat_to_req", 32'(n), 32'd3);
    chk("run_core_owns", 32'({mem_own, core_reset}), 32'd0);
  endtask

  task automatic done_at_10();
    int n;
    repeat (9) tick();
    core_done = 1'b1;
    n = 0;
    while (core_req && n < 20) begin
      tick();
      n++;
    end
    chk("done_to_req_low", 32'(n), 32'd2);
    core_done = 1'b0;
  endtask

  task automatic drain(input int stall_at);
    int n_hs, cyc;
    n_hs = 0;
    cyc  = 0;
    while (n_hs < RES_LEN && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        n_hs++;
        if (n_hs == stall_at) begin
          tick();
          out_ready = 1'b0;
          @(negedge clk);
          chk("rd_gap_no_valid", 32'(out_valid), 32'd0);
          tick();
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_hold", 32'({out_valid, out_data, mem_addr}),
                32'({1'b1, 8'hA0 + 8'(stall_at), 8'(RES_BASE + stall_at)}));
            tick();
          end
          out_ready = 1'b1;
        end
      end
    end
    chk("drain_beats", 32'(n_hs), 32'(RES_LEN));
    tick();
    chk("busy_after_drain", 32'({busy, err}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < RES_LEN; i++) mem[RES_BASE + i] = 8'hA0 + 8'(i);
    reset     = 1'b0;
    go        = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    core_done = 1'b0;
    #1;
    chk_reset_outputs("reset_values");
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // in_valid outside LOAD must not write
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("idle_ignores_in_valid", 32'({mem_wr_en, in_ready}), 32'd0);
      tick();
    end
    in_valid = 1'b0;

    // Normal run with a back-pressure stall on beat 3
    push_outs();
    load4(32'h11223344);
    wait_req();
    done_at_10();
    drain(3);

    // Timeout: no done
    load4(32'h01020304);
    wait_req();
    n = 1;
    while (core_req && n < 100) begin
      tick();
      if (core_req) n++;
    end
    chk("tmo_run_cycles", 32'(n), 32'(TMO));
    chk("tmo_status", 32'({err, busy, core_reset}), 32'({1'b1, 1'b0, 1'b1}));
    repeat (3) tick();
    @(negedge clk);
    chk("tmo_no_out_valid", 32'(out_valid), 32'd0);
    tick();

    // done_q and timeout in the same RUN cycle: done wins
    push_outs();
    load4(32'h05060708);
    wait_req();
    repeat (TMO - 2) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk("simul_done_wins", 32'({core_req, busy, err}), 32'({1'b0, 1'b1, 1'b0}));
    drain(99);

    // Reset during the second load beat, then a clean restart
    go = 1'b1;
    tick();
    go = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    wq.push_back({8'(LOAD_BASE), 8'h55});
    @(negedge clk);
    tick();
    in_data = 8'h66;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_load");
    tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    push_outs();
    load4(32'h71727374);
    wait_req();
    done_at_10();
    drain(99);

    chk("write_queue_empty", 32'(wq.size()), 32'd0);
    chk("out_queue_empty", 32'(oq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
